// File: rtl/serial_nibble_add_ctrl.sv
// Serial W-bit adder controller: sequences operands nibble by nibble through an external 4-bit adder.
// Optional feature macro SERIAL_ADD_OVF_EN adds the res_ovf two's-complement overflow output.
module serial_nibble_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   result,
`ifdef SERIAL_ADD_OVF_EN
  output logic                   res_ovf,
`endif
  output logic                   res_cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     result_r;
  logic             res_cout_r;
  logic [3:0]       a_nib_s;
  logic [3:0]       b_nib_s;
  logic             last_s;

  assign last_s   = (idx_r == LAST_IDX);
  assign result   = result_r;
  assign res_cout = res_cout_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start_valid only matters in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Select the operand nibbles addressed by idx (AND-OR mux, no priority).
  always_comb begin
    a_nib_s = 4'h0;
    b_nib_s = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      a_nib_s = a_nib_s | (a_r[4*i +: 4] & {4{idx_r == IDX_W'(i)}});
      b_nib_s = b_nib_s | (b_r[4*i +: 4] & {4{idx_r == IDX_W'(i)}});
    end
  end

  // Output decode: adder inputs are only driven while running.
  always_comb begin
    start_ready = 1'b0;
    res_valid   = 1'b0;
    add_a       = 4'h0;
    add_b       = 4'h0;
    add_cin     = 1'b0;
    case (state_r)
      IDLE: begin
        start_ready = 1'b1;
      end
      RUN: begin
        add_a   = a_nib_s;
        add_b   = b_nib_s;
        add_cin = carry_r;
      end
      DONE: begin
        res_valid = 1'b1;
      end
      default: begin
        start_ready = 1'b0;
      end
    endcase
  end

  // Operand capture, carry chain and nibble index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            a_r     <= op_a;
            b_r     <= op_b;
            carry_r <= op_cin;
            idx_r   <= '0;
          end
        end
        RUN: begin
          carry_r <= add_cout;
          // Hold at the last nibble so idx never wraps within a run.
          if (!last_s) begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        default: begin
          carry_r <= carry_r;
        end
      endcase
    end
  end

  // Result assembly; the previous sum is kept until the next run overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r   <= '0;
      res_cout_r <= 1'b0;
    end else begin
      if (state_r == RUN) begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_r == IDX_W'(i)) begin
            result_r[4*i +: 4] <= add_s;
          end
        end
        if (last_s) begin
          res_cout_r <= add_cout;
        end
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_r;

  // Signed overflow: like-signed operands whose sum sign differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else begin
      if ((state_r == RUN) && last_s) begin
        ovf_r <= (a_r[W-1] == b_r[W-1]) && (add_s[3] != a_r[W-1]);
      end
    end
  end

  assign res_ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_nibble_add_ctrl.sv
// Directed self-checking bench for serial_nibble_add_ctrl (NIBBLES=4) with a behavioural 4-bit adder.
module tb_serial_nibble_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] op_a = 16'h0000;
  logic [15:0] op_b = 16'h0000;
  logic        op_cin = 1'b0;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_s;
  logic        add_cout;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] result;
  logic        res_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic        res_ovf;
`endif

  int          total = 0;
  int          passed = 0;
  int          cycles;
  logic [7:0]  cin_trace;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  serial_nibble_add_ctrl #(.NIBBLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .add_s       (add_s),
    .add_cout    (add_cout),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
`ifdef SERIAL_ADD_OVF_EN
    .res_ovf     (res_ovf),
`endif
    .res_cout    (res_cout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one request and run until res_valid (bounded), recording add_cin per RUN cycle.
  task automatic run_to_done(input logic [15:0] a, input logic [15:0] b, input logic cin);
    op_a = a;
    op_b = b;
    op_cin = cin;
    start_valid = 1'b1;
    check("ready_before_accept", 32'(start_ready), 32'd1);
    step();
    start_valid = 1'b0;
    check("ready_in_run", 32'(start_ready), 32'd0);
    cycles = 0;
    cin_trace = 8'h00;
    while (!res_valid && cycles < 20) begin
      if (cycles < 8) cin_trace[cycles] = add_cin;
      step();
      cycles++;
    end
    check("latency", 32'(cycles), 32'd4);
    check("adder_a_done", 32'(add_a), 32'd0);
    check("adder_cin_done", 32'(add_cin), 32'd0);
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("valid_after_release", 32'(res_valid), 32'd0);
    check("ready_after_release", 32'(start_ready), 32'd1);
  endtask

  initial begin
    #2;
    check("rst_ready", 32'(start_ready), 32'd1);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(res_cout), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Zero add
    run_to_done(16'h0000, 16'h0000, 1'b0);
    check("zero_result", 32'(result), 32'h0000);
    check("zero_cout", 32'(res_cout), 32'd0);
    check("zero_cin_trace", 32'(cin_trace), 32'h00);
    release_result();
    check("idle_hold_result", 32'(result), 32'h0000);

    // Carry-in
    run_to_done(16'h0001, 16'h0001, 1'b1);
    check("cin_result", 32'(result), 32'h0003);
    check("cin_cout", 32'(res_cout), 32'd0);
    check("cin_trace", 32'(cin_trace), 32'h01);
    release_result();

    // Ripple wrap
    run_to_done(16'hFFFF, 16'h0001, 1'b0);
    check("wrap_result", 32'(result), 32'h0000);
    check("wrap_cout", 32'(res_cout), 32'd1);
    check("wrap_cin_trace", 32'(cin_trace), 32'h0E);
`ifdef SERIAL_ADD_OVF_EN
    check("wrap_ovf", 32'(res_ovf), 32'd0);
`endif
    release_result();

    // Signed overflow, then backpressure with start_valid high throughout DONE
    run_to_done(16'h7FFF, 16'h0001, 1'b0);
    check("ovf_result", 32'(result), 32'h8000);
    check("ovf_cout", 32'(res_cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("ovf_flag", 32'(res_ovf), 32'd1);
`endif
    op_a = 16'h1111;
    op_b = 16'h2222;
    start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_result", 32'(result), 32'h8000);
      check("bp_ready", 32'(start_ready), 32'd0);
      check("bp_valid", 32'(res_valid), 32'd1);
    end
`ifdef SERIAL_ADD_OVF_EN
    check("bp_ovf_hold", 32'(res_ovf), 32'd1);
`endif
    release_result();
    start_valid = 1'b0;
    check("bp_idle_result", 32'(result), 32'h8000);
    step();
    check("bp_still_idle", 32'(start_ready), 32'd1);

    // Reset mid-run (RUN cycle 2)
    op_a = 16'hFFFF;
    op_b = 16'h0001;
    op_cin = 1'b0;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    check("mid_run_cin", 32'(add_cin), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(start_ready), 32'd1);
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_cout", 32'(res_cout), 32'd0);
    check("arst_add_a", 32'(add_a), 32'd0);
    check("arst_add_cin", 32'(add_cin), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("arst_ovf", 32'(res_ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_to_done(16'h1234, 16'h4321, 1'b0);
    check("post_rst_result", 32'(result), 32'h5555);
    check("post_rst_cout", 32'(res_cout), 32'd0);
    release_result();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
